// File: rtl/display_pkg.sv
// Shared display helpers: digit-select polarity, counter widths and
// nibble slicing for multi-digit values feeding seven_seg decoders.
package display_pkg;

   localparam logic [7:0] SEL_IDLE_HIGH = 8'h00;
   localparam logic [7:0] SEL_IDLE_LOW  = 8'hFF;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [3:0] nibble(input logic [31:0] v,
                                         input int i);
      return v[4*i +: 4];
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler and digit index counter with next-state outputs so
// the scanner's output flops line up with the counter state.
module scan_prescaler
   import display_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000,
   localparam int PW = cnt_w(PRESCALE),
   localparam int IW = cnt_w(DIGITS)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [PW-1:0] pcnt_nxt,
   output logic [IW-1:0] idx_nxt,
   output logic          boundary
);

   logic [PW-1:0] pcnt;
   logic [IW-1:0] idx;
   logic          wrap;

   always_comb begin
      wrap     = (pcnt == PW'(PRESCALE - 1));
      boundary = wrap && (idx == IW'(DIGITS - 1));
      pcnt_nxt = wrap ? '0 : pcnt + PW'(1);
      if (boundary)
         idx_nxt = '0;
      else if (wrap)
         idx_nxt = idx + IW'(1);
      else
         idx_nxt = idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
         idx  <= '0;
      end else begin
         pcnt <= pcnt_nxt;
         idx  <= idx_nxt;
      end
   end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed digit scanner with dead time, leading-zero blanking
// and frame-boundary value updates, upstream of seven_seg.
module display_scan
   import display_pkg::*;
#(
   parameter int DIGITS           = 4,
   parameter int PRESCALE         = 1000,
   parameter int DEAD             = 2,
   parameter int ANODE_ACTIVE_LOW = 0,
   parameter int BLANK_LZ         = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [3:0]            bcd,
   output logic                  dp,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame_start
);

   localparam int PW = cnt_w(PRESCALE);
   localparam int IW = cnt_w(DIGITS);
   localparam logic [DIGITS-1:0] IDLE = (ANODE_ACTIVE_LOW != 0) ?
      SEL_IDLE_LOW[DIGITS-1:0] : SEL_IDLE_HIGH[DIGITS-1:0];

   logic [PW-1:0]       pcnt_nxt;
   logic [IW-1:0]       idx_nxt;
   logic                boundary;
   logic [4*DIGITS-1:0] act, act_n, pend;
   logic [DIGITS-1:0]   act_dp, act_dp_n, pend_dp;
   logic                pend_valid;
   logic [DIGITS-1:0]   blank, sel;
   logic                any;

   scan_prescaler #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE)
   ) u_pre (
      .clk      (clk),
      .rst_n    (rst_n),
      .pcnt_nxt (pcnt_nxt),
      .idx_nxt  (idx_nxt),
      .boundary (boundary)
   );

   // A load on the boundary edge bypasses pending straight into active.
   always_comb begin
      act_n    = act;
      act_dp_n = act_dp;
      if (boundary) begin
         if (load) begin
            act_n    = value;
            act_dp_n = dp_in;
         end else if (pend_valid) begin
            act_n    = pend;
            act_dp_n = pend_dp;
         end
      end
   end

   always_comb begin
      any   = 1'b0;
      blank = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         any = any || act_dp_n[i] ||
               (nibble(32'(act_n), i) != 4'd0);
         blank[i] = (BLANK_LZ != 0) && (i != 0) && !any;
      end
   end

   always_comb begin
      sel = '0;
      if (((DEAD == 0) || (pcnt_nxt >= PW'(DEAD))) && !blank[idx_nxt])
         sel[idx_nxt] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act         <= '0;
         act_dp      <= '0;
         pend        <= '0;
         pend_dp     <= '0;
         pend_valid  <= 1'b0;
         bcd         <= 4'd0;
         dp          <= 1'b0;
         digit_en    <= IDLE;
         frame_start <= 1'b0;
      end else begin
         act    <= act_n;
         act_dp <= act_dp_n;
         if (load) begin
            pend    <= value;
            pend_dp <= dp_in;
         end
         if (boundary)
            pend_valid <= 1'b0;
         else if (load)
            pend_valid <= 1'b1;
         bcd         <= nibble(32'(act_n), int'(idx_nxt));
         dp          <= act_dp_n[idx_nxt];
         digit_en    <= sel ^ IDLE;
         frame_start <= boundary;
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: frame-level reference model plus
// hand-computed spot values, two polarity/dead-time configurations.
module tb_display_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;

   logic [3:0] bcd0, bcd1, en0, en1;
   logic       dp0, dp1, fs0, fs1;

   int total = 0;
   int bad = 0;

   // reference model: cycles since reset and the displayed/pending words
   int          mc = 0;
   logic [15:0] m_act = '0, m_pend = '0;
   logic [3:0]  m_adp = '0, m_pdp = '0;
   logic        m_pv = 1'b0;
   bit          chk_on = 1'b0;

   always #5 clk = ~clk;

   display_scan #(
      .DIGITS(4), .PRESCALE(4), .DEAD(1),
      .ANODE_ACTIVE_LOW(0), .BLANK_LZ(1)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value),
      .dp_in(dp_in), .bcd(bcd0), .dp(dp0), .digit_en(en0),
      .frame_start(fs0)
   );

   display_scan #(
      .DIGITS(4), .PRESCALE(4), .DEAD(0),
      .ANODE_ACTIVE_LOW(1), .BLANK_LZ(1)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value),
      .dp_in(dp_in), .bcd(bcd1), .dp(dp1), .digit_en(en1),
      .frame_start(fs1)
   );

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s t=%0t mc=%0d got=%0h want=%0h",
                  nm, $time, mc, got, want);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mc = 0;
         m_act = '0; m_adp = '0;
         m_pend = '0; m_pdp = '0;
         m_pv = 1'b0;
      end else begin
         if (mc % 16 == 15) begin
            if (load) begin
               m_act = value; m_adp = dp_in;
            end else if (m_pv) begin
               m_act = m_pend; m_adp = m_pdp;
            end
            m_pv = 1'b0;
            if (load) begin
               m_pend = value; m_pdp = dp_in;
            end
         end else if (load) begin
            m_pend = value; m_pdp = dp_in; m_pv = 1'b1;
         end
         mc++;
      end
   end

   function automatic logic [3:0] exp_en(input int dead, input bit al);
      logic [3:0] e;
      int i, p;
      e = 4'b0000;
      if (mc > 0) begin
         i = (mc / 4) % 4;
         p = mc % 4;
         if (p >= dead &&
             !(i > 0 && (m_act >> (4*i)) == 0 && (m_adp >> i) == 0))
            e = 4'b0001 << i;
      end
      return al ? ~e : e;
   endfunction

   function automatic logic [3:0] exp_bcd();
      int i;
      i = (mc / 4) % 4;
      return (mc == 0) ? 4'd0 : 4'((m_act >> (4*i)) & 16'hF);
   endfunction

   function automatic logic exp_dp();
      int i;
      i = (mc / 4) % 4;
      return (mc == 0) ? 1'b0 : m_adp[i];
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         check("en0", en0, exp_en(1, 1'b0));
         check("en1", en1, exp_en(0, 1'b1));
         check("bcd0", bcd0, exp_bcd());
         check("bcd1", bcd1, exp_bcd());
         check("dp0", dp0, exp_dp());
         check("dp1", dp1, exp_dp());
         check("fs0", fs0, mc > 0 && mc % 16 == 0);
         check("fs1", fs1, mc > 0 && mc % 16 == 0);
         check("pv0", u0.pend_valid, m_pv);
      end
   end

   task automatic goto(input int t);
      int g;
      g = 0;
      while (mc < t && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("goto", mc, t);
   endtask

   task automatic pulse(input logic [15:0] v, input logic [3:0] d);
      value = v; dp_in = d; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      chk_on = 1'b1;
      repeat (3) begin
         @(negedge clk);
         value = 16'($urandom);
         dp_in = 4'($urandom);
         load  = 1'($urandom);
      end
      @(negedge clk);
      check("rst_en0", en0, 4'b0000);
      check("rst_en1", en1, 4'b1111);
      check("rst_bcd", bcd0, 4'd0);
      check("rst_fs", fs0, 1'b0);

      value = 16'h1234; dp_in = 4'b0000; load = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      load = 1'b0;
      goto(5);
      check("f0_blank", en0, 4'b0000);
      check("f0_bcd", bcd0, 4'd0);
      goto(16);
      check("f1_fs", fs0, 1'b1);
      check("f1_bcd", bcd0, 4'h4);
      check("f1_dead", en0, 4'b0000);
      check("f1_al", en1, 4'b1110);
      goto(17);
      check("f1_en", en0, 4'b0001);
      goto(29);
      check("f1_d3bcd", bcd0, 4'h1);
      check("f1_d3en", en0, 4'b1000);

      goto(34);
      pulse(16'h0042, 4'b0000);
      goto(53);
      check("lz_en1", en0, 4'b0010);
      check("lz_bcd1", bcd0, 4'h4);
      goto(57);
      check("lz_en2", en0, 4'b0000);

      goto(66);
      pulse(16'h0000, 4'b0000);
      goto(81);
      check("zero_en", en0, 4'b0001);
      check("zero_bcd", bcd0, 4'h0);
      goto(85);
      check("zero_blank", en0, 4'b0000);

      goto(98);
      pulse(16'h0042, 4'b0100);
      goto(121);
      check("dp_en2", en0, 4'b0100);
      check("dp_dp2", dp0, 1'b1);
      goto(125);
      check("dp_en3", en0, 4'b0000);

      goto(133);
      pulse(16'hABCD, 4'b0000);
      goto(137);
      pulse(16'h5678, 4'b0000);
      goto(138);
      check("mid_hold", en0, 4'b0100);
      goto(145);
      check("mid_last0", bcd0, 4'h8);
      goto(157);
      check("mid_last3", bcd0, 4'h5);

      goto(175);
      pulse(16'h9999, 4'b0000);
      check("bnd_fs", fs0, 1'b1);
      check("bnd_bcd", bcd0, 4'h9);
      check("bnd_pv", u0.pend_valid, 1'b0);
      goto(177);
      check("bnd_en", en0, 4'b0001);

      goto(203);
      #2 rst_n = 1'b0;
      #1;
      check("async_en0", en0, 4'b0000);
      check("async_en1", en1, 4'b1111);
      check("async_bcd", bcd0, 4'd0);
      check("async_fs", fs0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      goto(15);
      check("rr_fs15", fs0, 1'b0);
      goto(16);
      check("rr_fs16", fs0, 1'b1);
      check("rr_bcd", bcd0, 4'd0);
      goto(21);
      check("rr_blank", en0, 4'b0000);
      goto(24);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
